core_maxpool2d_1: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the first conv2d filter core. It pops one signed DWIDTH-bit feature-map pixel per read from the conv output FIFO, in raster order. It pushes one pooled pixel per 2x2 window into the next-layer input FIFO. Frame geometry is set at elaboration time, and one output register absorbs downstream backpressure.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/core_maxpool2d_1_if.sv | 43 ++++
 rtl/maxpool_line_buffer.sv | 35 +++
 rtl/core_maxpool2d_1.sv | 134 +++++++++++++
 tb/tb_core_maxpool2d_1.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : shared CNN datapath types, signed max helper, geometry checks
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int DWIDTH_DEFAULT = 32;
    localparam int MAX_DWIDTH     = 64;

    typedef logic signed [MAX_DWIDTH-1:0] wide_t;

    // Role of an accepted pixel inside its 2x2 window, from (row, col) parity.
    typedef enum logic [1:0] {
        PH_HOLD     = 2'd0,
        PH_LB_WRITE = 2'd1,
        PH_EMIT     = 2'd2
    } win_phase_e;

    // Callers sign-extend into wide_t so one helper covers every pixel width.
    function automatic wide_t smax(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit dims_ok(input int w, input int h);
        return (w >= 2) && (h >= 2) && ((w % 2) == 0) && ((h % 2) == 0);
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_maxpool2d_1_if.sv
// ============================================================================
// core_maxpool2d_1_if : input-FIFO pop side and output-FIFO push side
// Rev 1.0
// ============================================================================
`default_nettype none

interface core_maxpool2d_1_if
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT
);

    logic [DWIDTH-1:0] ff_rdata;
    logic              ff_empty;
    logic              ff_rdreq;
    logic [DWIDTH-1:0] ff_wdata;
    logic              ff_wrreq;
    logic              ff_full;
    logic              frame_done;

    modport master (
        input  ff_rdata,
        input  ff_empty,
        input  ff_full,
        output ff_rdreq,
        output ff_wdata,
        output ff_wrreq,
        output frame_done
    );

    modport slave (
        output ff_rdata,
        output ff_empty,
        output ff_full,
        input  ff_rdreq,
        input  ff_wdata,
        input  ff_wrreq,
        input  frame_done
    );

endinterface

`default_nettype wire

// File: rtl/maxpool_line_buffer.sv
// ============================================================================
// maxpool_line_buffer : horizontal-pair maxima of the even row, 1W / 1 async R
// Rev 1.0
// ============================================================================
`default_nettype none

module maxpool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clock,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DWIDTH-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DWIDTH-1:0] rdata
);

    // Contents are always written on an even row before an odd row reads them.
    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/core_maxpool2d_1.sv
// ============================================================================
// core_maxpool2d_1 : streaming 2x2 stride-2 signed max-pool, raster in/out
// Rev 1.0
// ============================================================================
`default_nettype none

module core_maxpool2d_1
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  wire logic           clock,
    input  wire logic           reset,
    core_maxpool2d_1_if.master  bus
);

    localparam int CW       = clog2_min1(IMG_W);
    localparam int RW       = clog2_min1(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = clog2_min1(LB_DEPTH);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    generate
        if (!dims_ok(IMG_W, IMG_H) || (DWIDTH < 1) || (DWIDTH > MAX_DWIDTH)) begin : g_param_check
            $error("core_maxpool2d_1: IMG_W/IMG_H must be even and >= 2, DWIDTH in 1..64");
        end
    endgenerate

    logic                     rd_d;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DWIDTH-1:0] h_reg;
    logic signed [DWIDTH-1:0] out_data;
    logic                     out_valid;
    logic                     last_flag;

    logic signed [DWIDTH-1:0] pixel;
    logic signed [DWIDTH-1:0] pair_max;
    logic signed [DWIDTH-1:0] win_max;
    logic signed [DWIDTH-1:0] lb_rdata;
    logic [AW-1:0]            lb_addr;
    win_phase_e               phase;
    logic                     lb_we;
    logic                     load;
    logic                     push;
    logic                     at_last;

    // Reads pause only while a finished result is stuck behind a full output.
    assign bus.ff_rdreq   = !reset && !bus.ff_empty && !(out_valid && bus.ff_full);
    assign push           = out_valid && !bus.ff_full;
    assign bus.ff_wrreq   = push;
    assign bus.ff_wdata   = out_data;
    assign bus.frame_done = push && last_flag;

    assign pixel   = bus.ff_rdata;
    assign lb_addr = AW'(col >> 1);
    assign at_last = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        phase = PH_HOLD;
        if (col[0]) begin
            phase = row[0] ? PH_EMIT : PH_LB_WRITE;
        end
    end

    assign pair_max = DWIDTH'(smax(wide_t'(h_reg), wide_t'(pixel)));
    assign win_max  = DWIDTH'(smax(wide_t'(lb_rdata), wide_t'(pair_max)));
    assign lb_we    = rd_d && (phase == PH_LB_WRITE);
    assign load     = rd_d && (phase == PH_EMIT);

    maxpool_line_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (LB_DEPTH),
        .ADDR_W (AW)
    ) u_line_buffer (
        .clock (clock),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_d  <= 1'b0;
            col   <= '0;
            row   <= '0;
            h_reg <= '0;
        end else begin
            rd_d <= bus.ff_rdreq;
            if (rd_d) begin
                if (phase == PH_HOLD) begin
                    h_reg <= pixel;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // A new result overrides the clear from a simultaneous push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            last_flag <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= win_max;
                out_valid <= 1'b1;
            end else if (push) begin
                out_valid <= 1'b0;
            end
            if (push) begin
                last_flag <= 1'b0;
            end
            if (load && at_last) begin
                last_flag <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_maxpool2d_1.sv
// ============================================================================
// tb_core_maxpool2d_1 : directed + randomized checks of the 4x4 max-pool stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_maxpool2d_1;

    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    core_maxpool2d_1_if #(.DWIDTH(DW)) bus ();

    core_maxpool2d_1 #(
        .DWIDTH (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int     vectors     = 0;
    int     miscompares = 0;

    int     inq[$];
    int     expq[$];
    bit     explast[$];
    longint latq[$];

    longint cyc = 0;
    bit     req_prev = 0;
    int     pos = 0;
    int     delivered = 0;
    int     pushes = 0;
    int     dones = 0;
    int     extra = 0;
    int     empty_mode = 0;
    int     full_mode = 0;
    bit     check_lat = 0;
    int     hold_cnt = 0;
    bit     hold_pending = 0;
    bit     hold_used = 0;
    int     frame[NPIX];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: each output is the max of its 2x2 block, in raster window order.
    task automatic add_frame(input int f[NPIX]);
        for (int i = 0; i < NPIX; i++) inq.push_back(f[i]);
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                int m;
                m = f[(2 * wr) * W + 2 * wc];
                if (f[(2 * wr) * W + 2 * wc + 1] > m)     m = f[(2 * wr) * W + 2 * wc + 1];
                if (f[(2 * wr + 1) * W + 2 * wc] > m)     m = f[(2 * wr + 1) * W + 2 * wc];
                if (f[(2 * wr + 1) * W + 2 * wc + 1] > m) m = f[(2 * wr + 1) * W + 2 * wc + 1];
                expq.push_back(m);
                explast.push_back((wr == H / 2 - 1) && (wc == W / 2 - 1));
            end
        end
    endtask

    task automatic run_cycle();
        bit holding;
        bit empty_stall;
        @(posedge clock);
        cyc++;
        #1;
        holding = (hold_cnt > 0);
        if (req_prev) begin
            if (inq.size() > 0) begin
                bus.ff_rdata = inq.pop_front();
                delivered++;
                if (((pos / W) % 2 == 1) && ((pos % W) % 2 == 1)) begin
                    latq.push_back(cyc);
                    if (full_mode == 1 && !hold_used) begin
                        hold_pending = 1;
                        hold_used    = 1;
                    end
                end
                pos = (pos + 1) % NPIX;
            end else begin
                check("rdreq_on_empty", 32'(req_prev), 0);
            end
        end else begin
            bus.ff_rdata = $urandom;
        end
        case (empty_mode)
            1:       empty_stall = (cyc % 2) == 1;
            2:       empty_stall = ($urandom_range(0, 2) == 0);
            default: empty_stall = 0;
        endcase
        bus.ff_empty = (inq.size() == 0) || empty_stall;
        bus.ff_full  = holding || (full_mode == 2 && $urandom_range(0, 2) == 0);
        #1;
        req_prev = bus.ff_rdreq;
        if (holding) begin
            check("hold_wrreq", 32'(bus.ff_wrreq), 0);
            check("hold_rdreq", 32'(bus.ff_rdreq), 0);
            if (expq.size() > 0) check("hold_wdata", bus.ff_wdata, expq[0]);
            hold_cnt--;
        end
        if (hold_pending) begin
            hold_cnt     = 5;
            hold_pending = 0;
        end
        if (bus.frame_done) dones++;
        if (bus.ff_wrreq) begin
            pushes++;
            if (expq.size() == 0) begin
                extra++;
            end else begin
                int     e;
                bit     l;
                longint t;
                e = expq.pop_front();
                l = explast.pop_front();
                check("wdata", bus.ff_wdata, e);
                check("frame_done", 32'(bus.frame_done), 32'(l));
                if (latq.size() > 0) begin
                    t = latq.pop_front();
                    if (check_lat) check("latency", 32'(cyc - t), 1);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((expq.size() > 0 || inq.size() > 0) && n < 2000) begin
            run_cycle();
            n++;
        end
        check({tag, "_drain_timeout"}, expq.size(), 0);
        repeat (4) run_cycle();
        check({tag, "_extra_pushes"}, extra, 0);
    endtask

    task automatic start_scenario(input int em, input int fm, input bit lat);
        empty_mode = em;
        full_mode  = fm;
        check_lat  = lat;
        pushes     = 0;
        dones      = 0;
        extra      = 0;
        delivered  = 0;
        hold_used  = 0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.ff_empty = 1'b0;
        bus.ff_full  = 1'b0;
        inq.delete();
        expq.delete();
        explast.delete();
        latq.delete();
        pos          = 0;
        req_prev     = 0;
        hold_cnt     = 0;
        hold_pending = 0;
        #1;
        check("rst_rdreq", 32'(bus.ff_rdreq), 0);
        check("rst_wrreq", 32'(bus.ff_wrreq), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_wdata", bus.ff_wdata, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.ff_empty = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.ff_rdata = '0;
        bus.ff_empty = 1'b1;
        bus.ff_full  = 1'b0;
        #2;
        do_reset();

        // Plain raster 1..16
        start_scenario(0, 0, 1);
        for (int i = 0; i < NPIX; i++) frame[i] = i + 1;
        add_frame(frame);
        drain("s1");
        check("s1_pushes", pushes, 4);
        check("s1_dones", dones, 1);

        // All negative: exercises signed comparison
        start_scenario(0, 0, 1);
        for (int i = 0; i < NPIX; i++) frame[i] = i - 16;
        add_frame(frame);
        drain("s2");
        check("s2_pushes", pushes, 4);

        // Output full for 5 cycles at the first result
        start_scenario(0, 1, 0);
        for (int i = 0; i < NPIX; i++) frame[i] = i + 1;
        add_frame(frame);
        drain("s3");
        check("s3_pushes", pushes, 4);
        check("s3_hold_seen", 32'(hold_used), 1);

        // Input empty toggling every other cycle
        start_scenario(1, 0, 1);
        add_frame(frame);
        drain("s4");
        check("s4_pushes", pushes, 4);

        // Two back-to-back frames
        start_scenario(0, 0, 1);
        add_frame(frame);
        for (int i = 0; i < NPIX; i++) frame[i] = 16 - (i + 1);
        add_frame(frame);
        drain("s5");
        check("s5_pushes", pushes, 8);
        check("s5_dones", dones, 2);

        // Reset after 7 pixels, then a fresh frame
        start_scenario(0, 0, 1);
        for (int i = 0; i < NPIX; i++) frame[i] = i + 1;
        add_frame(frame);
        begin
            int n;
            n = 0;
            while (delivered < 7 && n < 200) begin
                run_cycle();
                n++;
            end
        end
        check("s6_reached_7", delivered, 7);
        do_reset();
        start_scenario(0, 0, 1);
        add_frame(frame);
        drain("s6");
        check("s6_pushes", pushes, 4);
        check("s6_dones", dones, 1);

        // Randomized pixels with random empty/full stalls
        start_scenario(2, 2, 0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                if ($urandom_range(0, 1) == 1) frame[i] = int'($urandom);
                else                           frame[i] = int'($urandom_range(0, 7)) - 4;
            end
            add_frame(frame);
        end
        drain("s7");
        check("s7_pushes", pushes, 12);
        check("s7_dones", dones, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
